// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and width defaults for mem_arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY0   = 2'd1,
    ST_BUSY1   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a single cache-line memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,

  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              dropped_q, dropped_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              grant;

  // Returns the index of the requester to serve; on a tie the one not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

  assign grant = rr_pick(m0_enable_i, m1_enable_i, last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    dropped_d    = dropped_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_enable_i || m1_enable_i) begin
          last_grant_d = grant;
          dropped_d    = 1'b0;
          if (grant) begin
            write_d = m1_write_i;
            addr_d  = m1_addr_i;
            data_d  = m1_data_i;
            state_d = ST_BUSY1;
          end else begin
            write_d = m0_write_i;
            addr_d  = m0_addr_i;
            data_d  = m0_data_i;
            state_d = ST_BUSY0;
          end
        end
      end

      // An abandoned request still completes at memory; its ack is simply not forwarded.
      ST_BUSY0: begin
        if (!m0_enable_i) begin
          dropped_d = 1'b1;
        end
        if (mem_ack_i) begin
          m0_ack_o = m0_enable_i && !dropped_q;
          state_d  = ST_RELEASE;
        end
      end

      ST_BUSY1: begin
        if (!m1_enable_i) begin
          dropped_d = 1'b1;
        end
        if (mem_ack_i) begin
          m1_ack_o = m1_enable_i && !dropped_q;
          state_d  = ST_RELEASE;
        end
      end

      ST_RELEASE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      dropped_q    <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      dropped_q    <= dropped_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign mem_enable_o = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign m0_data_o    = mem_data_i;
  assign m1_data_o    = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i, mem_addr_o;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, mem_ack_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] pat_a5, pat_wr, pat_b;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m0_enable_i  (m0_enable_i),
    .m0_write_i   (m0_write_i),
    .m0_addr_i    (m0_addr_i),
    .m0_data_i    (m0_data_i),
    .m0_data_o    (m0_data_o),
    .m0_ack_o     (m0_ack_o),
    .m1_enable_i  (m1_enable_i),
    .m1_write_i   (m1_write_i),
    .m1_addr_i    (m1_addr_i),
    .m1_data_i    (m1_data_i),
    .m1_data_o    (m1_data_o),
    .m1_ack_o     (m1_ack_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_en"}, mem_enable_o, 1'b0);
    chk({tag, "_ack0"}, m0_ack_o, 1'b0);
    chk({tag, "_ack1"}, m1_ack_o, 1'b0);
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_wr = {4{64'h0123456789ABCDEF}};
    pat_b  = {8{32'hDEADBEEF}};

    rst_i = 1'b0;
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    mem_data_i = '0; mem_ack_i = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_en", mem_enable_o, 1'b0);
    chk("rst_wr", mem_write_o, 1'b0);
    chk("rst_addr", mem_addr_o, '0);
    chk("rst_data", mem_data_o, '0);
    chk("rst_ack0", m0_ack_o, 1'b0);
    chk("rst_ack1", m1_ack_o, 1'b0);
    rst_i = 1'b1;

    // Scenario 2: tie right after reset, m0 first, then m1, then m0 wins the next tie
    m0_enable_i = 1'b1; m0_addr_i = 32'h100; m0_data_i = pat_b;
    m1_enable_i = 1'b1; m1_addr_i = 32'h200;
    tick();
    chk("tie1_en", mem_enable_o, 1'b1);
    chk("tie1_addr", mem_addr_o, 32'h100);
    mem_ack_i = 1'b1; mem_data_i = pat_b; #1;
    chk("tie1_ack0", m0_ack_o, 1'b1);
    chk("tie1_ack1", m1_ack_o, 1'b0);
    chk("tie1_d0", m0_data_o, pat_b);
    tick();
    m0_enable_i = 1'b0; #1;
    chk_idle_outs("tie1_rel");
    mem_ack_i = 1'b0;
    tick();
    chk("tie1_idle_en", mem_enable_o, 1'b0);
    tick();
    chk("tie2_en", mem_enable_o, 1'b1);
    chk("tie2_addr", mem_addr_o, 32'h200);
    mem_ack_i = 1'b1; #1;
    chk("tie2_ack1", m1_ack_o, 1'b1);
    chk("tie2_ack0", m0_ack_o, 1'b0);
    tick();
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    tick();
    m0_enable_i = 1'b1; m1_enable_i = 1'b1;
    tick();
    chk("tie3_addr", mem_addr_o, 32'h100);
    chk("tie3_en", mem_enable_o, 1'b1);
    mem_ack_i = 1'b1; #1;
    chk("tie3_ack0", m0_ack_o, 1'b1);
    tick();
    mem_ack_i = 1'b0; m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    tick();
    // Next IDLE sees m1 pending from the tie above? No: both dropped; state is IDLE.
    chk("tie3_idle_en", mem_enable_o, 1'b0);

    // Scenario 1: m1 read at 0x420, ack after 10 cycles of enable
    m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h420;
    tick();
    chk("s1_en", mem_enable_o, 1'b1);
    chk("s1_addr", mem_addr_o, 32'h420);
    chk("s1_wr", mem_write_o, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    chk("s1_en_hold", mem_enable_o, 1'b1);
    chk("s1_noack", m1_ack_o, 1'b0);
    mem_ack_i = 1'b1; mem_data_i = pat_a5; #1;
    chk("s1_ack1", m1_ack_o, 1'b1);
    chk("s1_d1", m1_data_o, pat_a5);
    chk("s1_ack0", m0_ack_o, 1'b0);
    tick();
    mem_ack_i = 1'b0; m1_enable_i = 1'b0; #1;
    chk_idle_outs("s1_rel");
    tick();
    chk_idle_outs("s1_idle");

    // Scenario 3: m1 write, data captured at grant regardless of later changes
    m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h7E0; m1_data_i = pat_wr;
    tick();
    m1_data_i = ~pat_wr; m1_addr_i = 32'h0; m1_write_i = 1'b0;
    chk("s3_wr", mem_write_o, 1'b1);
    chk("s3_addr", mem_addr_o, 32'h7E0);
    chk("s3_data", mem_data_o, pat_wr);
    tick(); tick(); tick();
    chk("s3_data_hold", mem_data_o, pat_wr);
    chk("s3_wr_hold", mem_write_o, 1'b1);
    chk("s3_addr_hold", mem_addr_o, 32'h7E0);
    mem_ack_i = 1'b1; #1;
    chk("s3_ack1", m1_ack_o, 1'b1);
    tick();
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    tick();

    // Scenario 4: m0 abandons its request mid-transaction
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h340;
    tick();
    chk("s4_en", mem_enable_o, 1'b1);
    tick(); tick(); tick();
    m0_enable_i = 1'b0;
    tick(); tick();
    chk("s4_en_hold", mem_enable_o, 1'b1);
    chk("s4_addr", mem_addr_o, 32'h340);
    mem_ack_i = 1'b1; #1;
    chk("s4_ack0", m0_ack_o, 1'b0);
    chk("s4_ack1", m1_ack_o, 1'b0);
    tick();
    mem_ack_i = 1'b0; #1;
    chk_idle_outs("s4_rel");
    tick();
    chk_idle_outs("s4_idle");

    // Scenario 5: reset asserted 4 cycles into BUSY1
    m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h555; m1_data_i = pat_b;
    tick();
    chk("s5_en", mem_enable_o, 1'b1);
    tick(); tick(); tick(); tick();
    mem_ack_i = 1'b1;
    rst_i = 1'b0; #1;
    chk("s5_rst_en", mem_enable_o, 1'b0);
    chk("s5_rst_wr", mem_write_o, 1'b0);
    chk("s5_rst_addr", mem_addr_o, '0);
    chk("s5_rst_data", mem_data_o, '0);
    chk("s5_rst_ack1", m1_ack_o, 1'b0);
    mem_ack_i = 1'b0;
    tick();
    rst_i = 1'b1; #1;
    chk("s5_idle_en", mem_enable_o, 1'b0);
    tick();
    chk("s5_regrant_en", mem_enable_o, 1'b1);
    chk("s5_regrant_addr", mem_addr_o, 32'h555);
    chk("s5_regrant_data", mem_data_o, pat_b);
    mem_ack_i = 1'b1; #1;
    chk("s5_ack1", m1_ack_o, 1'b1);
    tick();
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    tick();

    // Scenario 6: spurious memory ack while idle
    mem_ack_i = 1'b1; #1;
    chk_idle_outs("s6_a");
    tick();
    chk_idle_outs("s6_b");
    tick();
    mem_ack_i = 1'b0;
    m0_enable_i = 1'b1; m0_addr_i = 32'h9C0;
    tick();
    chk("s6_grant_en", mem_enable_o, 1'b1);
    chk("s6_grant_addr", mem_addr_o, 32'h9C0);
    mem_ack_i = 1'b1; #1;
    chk("s6_ack0", m0_ack_o, 1'b1);
    tick();
    mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, cache-line width in bits.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_enable_i / m0_write_i  input  1 each  requester 0 (instruction cache) request and write flag.
REQ-006 SHALL have ports m0_addr_i  input  ADDR_W, m0_data_i  input  DATA_W, m0_data_o  output  DATA_W, m0_ack_o  output  1.
REQ-007 SHALL have ports m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o with the same widths and directions as m0; requester 1 is the data cache.
REQ-008 SHALL have ports mem_enable_o  output  1, mem_write_o  output  1, mem_addr_o  output  ADDR_W, mem_data_o  output  DATA_W.
REQ-009 SHALL have ports mem_data_i  input  DATA_W and mem_ack_i  input  1, from the data memory.

Function
REQ-010 SHALL implement states IDLE, BUSY0, BUSY1 and RELEASE.
REQ-011 In IDLE, with exactly one mX_enable_i high, the block SHALL move to BUSYX on the next edge.
REQ-012 In IDLE, with both requests high, the block SHALL grant the requester other than last_grant (round-robin), then set last_grant to the winner.
REQ-013 On the grant edge, the block SHALL latch the winner's addr, write and data into mem_addr_o, mem_write_o and mem_data_o; these SHALL stay stable until the transaction ends.
REQ-014 mem_enable_o SHALL be 1 exactly in BUSY0/BUSY1, which gives request-to-memory-enable latency of 1 cycle.
REQ-015 In BUSYX with mem_ack_i high, mX_ack_o SHALL equal 1 combinationally in that same cycle, and the block SHALL move to RELEASE.
REQ-016 mX_data_o SHALL equal mem_data_i at all times; requesters qualify it with mX_ack_o.
REQ-017 The non-granted requester's ack SHALL be 0 always; each ack SHALL be a 1-cycle pulse per transaction.
REQ-018 RELEASE SHALL last exactly 1 cycle with mem_enable_o=0, ignore all requests, then return to IDLE; this lets a requester drop its enable after ack.
REQ-019 If the granted requester's enable falls before mem_ack_i, the transaction SHALL still complete to memory; the ack SHALL be swallowed (mX_ack_o stays 0), and the state SHALL go to RELEASE.
REQ-020 mem_ack_i seen in IDLE or RELEASE SHALL be ignored.
REQ-021 A request arriving in BUSY or RELEASE SHALL wait; no request SHALL be dropped while its enable is held.
REQ-022 Worst-case wait for a held request SHALL be one foreign transaction plus 2 cycles.

Reset
REQ-023 Reset SHALL force: state=IDLE; last_grant=1, so m0 wins the first tie; mem_enable_o=0; mem_write_o=0; mem_addr_o=0; mem_data_o=0; m0_ack_o=m1_ack_o=0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no ack issued.

Structure
REQ-025 A shared package SHALL hold the state encoding (2 bits: IDLE=0, BUSY0=1, BUSY1=2, RELEASE=3) and the ADDR_W/DATA_W defaults.
REQ-026 The block SHALL be flat, with no sub-modules; the round-robin pick SHALL be an inline function.

Verification
REQ-027 Scenario 1: m1 read, addr 0x0000_0420, memory acks 10 cycles after enable with data 0xA5..A5 -> mem_enable_o rises 1 cycle after request and mem_addr_o=0x420, mem_write_o=0; m1_ack_o pulses 1 cycle with m1_data_o=0xA5..A5; RELEASE follows, then IDLE.
REQ-028 Scenario 2: m0 and m1 both requested in the first cycle after reset -> m0 served first, m1 granted in the cycle after RELEASE; next simultaneous tie -> m0 wins again, because last_grant alternates.
REQ-029 Scenario 3: m1 write, addr 0x0000_07E0, data pattern 0x1..F repeated -> mem_write_o=1 and mem_data_o holds the pattern through the whole BUSY1 even if m1_data_i changes after grant.
REQ-030 Scenario 4: m0 drops enable 3 cycles into BUSY0 -> mem_enable_o held until mem_ack_i, m0_ack_o stays 0, return to IDLE.
REQ-031 Scenario 5: rst_i pulled low 4 cycles into BUSY1 -> all outputs 0 asynchronously; after release, a pending m1 request is granted afresh.
REQ-032 Scenario 6: spurious mem_ack_i in IDLE -> no ack on either requester, no state change.
